irrigation_zone_scheduler: RTL and testbench

- Shares one irrigation pump among NZ garden zones; each zone raises a level "dry" request and owns a programmable watering duration.
- A round-robin arbiter grants one zone at a time, then sequences: valve open, settle, pump run for the zone's duration, pump stop, valve close, inter-zone gap.
- Sits above the per-pump watering timer and drives pump enable and per-zone valves directly.

---
 rtl/irrigation_zone_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_irrigation_zone_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin pump/valve sequencer sharing one pump among NZ irrigation zones.
// Optional RAIN_LOCKOUT_EN: rain blocks new grants and aborts an active OPEN/RUN phase.
module irrigation_zone_scheduler #(
    parameter int NZ     = 4,
    parameter int SETTLE = 3,
    parameter int GAP    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [NZ-1:0]   zone_req,
    input  logic [8*NZ-1:0] zone_dur,
    input  logic            rain,
    output logic            pump_on,
    output logic [NZ-1:0]   valve_open,
    output logic            busy,
    output logic [2:0]      active_zone,
    output logic [7:0]      remaining,
    output logic            done_pulse,
    output logic [2:0]      done_zone
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_RUN,
        S_CLOSE,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    dur_q, dur_d;
    logic [7:0]    rem_q, rem_d;
    logic          pump_q, pump_d;
    logic [NZ-1:0] valve_q, valve_d;
    logic          done_q, done_d;
    logic [2:0]    done_zone_q, done_zone_d;
    logic          abort_q, abort_d;
    logic          rain_lock;

`ifdef RAIN_LOCKOUT_EN
    assign rain_lock = rain;
`else
    logic unused_rain;
    assign unused_rain = rain;
    assign rain_lock   = 1'b0;
`endif

    logic [NZ-1:0] elig;
    logic [7:0]    dur_arr [NZ];

    for (genvar g = 0; g < NZ; g++) begin : g_zone
        assign dur_arr[g] = zone_dur[8*g +: 8];
        assign elig[g]    = zone_req[g] && (dur_arr[g] != 8'd0);
    end

    logic       grant_vld;
    logic [2:0] grant_idx;
    logic [7:0] grant_dur;

    // Rank 0 is the zone just after the pointer; the last-served zone ranks lowest.
    always_comb begin : arb
        int best_rank;
        int rank;
        best_rank = NZ;
        rank      = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_dur = '0;
        for (int j = 0; j < NZ; j++) begin
            rank = (j + NZ - 1 - int'(ptr_q)) % NZ;
            if (elig[j] && rank < best_rank) begin
                best_rank = rank;
                grant_vld = 1'b1;
                grant_idx = 3'(j);
                grant_dur = dur_arr[j];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        dur_d       = dur_q;
        rem_d       = rem_q;
        pump_d      = pump_q;
        valve_d     = valve_q;
        done_d      = 1'b0;
        done_zone_d = done_zone_q;
        abort_d     = abort_q;
        case (state_q)
            S_IDLE: begin
                if (enable && grant_vld && !rain_lock) begin
                    idx_d   = grant_idx;
                    dur_d   = grant_dur;
                    valve_d = NZ'(1) << grant_idx;
                    cnt_d   = 4'(SETTLE);
                    abort_d = 1'b0;
                    state_d = S_OPEN;
                end
            end
            S_OPEN: begin
                if (rain_lock) begin
                    cnt_d   = 4'(SETTLE);
                    abort_d = 1'b1;
                    state_d = S_CLOSE;
                end else if (cnt_q == 4'd1) begin
                    pump_d  = 1'b1;
                    rem_d   = dur_q;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RUN: begin
                if (rain_lock || rem_q == 8'd1) begin
                    pump_d  = 1'b0;
                    rem_d   = 8'd0;
                    cnt_d   = 4'(SETTLE);
                    abort_d = rain_lock;
                    state_d = S_CLOSE;
                end else begin
                    rem_d = rem_q - 8'd1;
                end
            end
            S_CLOSE: begin
                if (cnt_q == 4'd1) begin
                    valve_d = '0;
                    ptr_d   = idx_q;
                    if (!abort_q) begin
                        done_d      = 1'b1;
                        done_zone_d = idx_q;
                    end
                    if (GAP == 0) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = 4'(GAP);
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 4'd1) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= 3'(NZ - 1);
            idx_q       <= '0;
            dur_q       <= '0;
            rem_q       <= '0;
            pump_q      <= 1'b0;
            valve_q     <= '0;
            done_q      <= 1'b0;
            done_zone_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            dur_q       <= dur_d;
            rem_q       <= rem_d;
            pump_q      <= pump_d;
            valve_q     <= valve_d;
            done_q      <= done_d;
            done_zone_q <= done_zone_d;
            abort_q     <= abort_d;
        end
    end

    assign pump_on     = pump_q;
    assign valve_open  = valve_q;
    assign busy        = (state_q != S_IDLE);
    assign active_zone = idx_q;
    assign remaining   = rem_q;
    assign done_pulse  = done_q;
    assign done_zone   = done_zone_q;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Bench for irrigation_zone_scheduler: vector table plus hand sequences, with a
// scoreboard queue of expected grants checked by a cycle monitor.
module tb_irrigation_zone_scheduler;

    localparam int NZ     = 4;
    localparam int SETTLE = 3;
    localparam int GAP    = 2;

    logic            clk;
    logic            reset;
    logic            enable;
    logic [NZ-1:0]   zone_req;
    logic [8*NZ-1:0] zone_dur;
    logic            rain;
    logic            pump_on;
    logic [NZ-1:0]   valve_open;
    logic            busy;
    logic [2:0]      active_zone;
    logic [7:0]      remaining;
    logic            done_pulse;
    logic [2:0]      done_zone;

    irrigation_zone_scheduler #(.NZ(NZ), .SETTLE(SETTLE), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .enable(enable), .zone_req(zone_req),
        .zone_dur(zone_dur), .rain(rain), .pump_on(pump_on),
        .valve_open(valve_open), .busy(busy), .active_zone(active_zone),
        .remaining(remaining), .done_pulse(done_pulse), .done_zone(done_zone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] zone;
        int         dur;
        int         run;
        logic       done;
    } exp_t;

    typedef struct {
        logic        en;
        logic [3:0]  req;
        logic [31:0] dur;
        logic        grant;
        logic [2:0]  zone;
        int          run;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   grants = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Independent cycle monitor: grant order, timing, remaining, done and invariants.
    exp_t          cur;
    int            cyc = 0, c_open = 0, c_pfall = 0, c_vfall = 0, run = 0;
    logic          busy_chk = 1'b0;
    logic [NZ-1:0] prev_valve = '0;
    logic          prev_pump = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            busy_chk   = 1'b0;
            prev_valve = '0;
            prev_pump  = 1'b0;
            check("done_in_reset", done_pulse, 0);
        end else begin
            check("valve_onehot", ($countones(valve_open) <= 1), 1);
            check("pump_needs_valve", (pump_on && valve_open == '0), 0);
            if (!busy) check("idle_zone", active_zone, 0);
            if (valve_open != '0 && prev_valve == '0) begin
                grants++;
                if (sb_q.size() == 0) begin
                    check("unexpected_grant", valve_open, 0);
                    cur = '{zone: 3'd0, dur: 0, run: 0, done: 1'b0};
                end else begin
                    cur = sb_q.pop_front();
                    check("grant_valve", valve_open, 32'(1) << cur.zone);
                    check("grant_zone", active_zone, cur.zone);
                    check("grant_busy", busy, 1);
                end
                c_open = cyc;
                run    = 0;
            end
            if (pump_on && !prev_pump) check("settle_open", cyc - c_open, SETTLE);
            if (pump_on) begin
                run++;
                check("remaining", remaining, cur.dur - run + 1);
            end else begin
                check("rem_zero", remaining, 0);
            end
            if (!pump_on && prev_pump) begin
                check("run_len", run, cur.run);
                c_pfall = cyc;
            end
            if (valve_open == '0 && prev_valve != '0) begin
                check("settle_close", cyc - c_pfall, SETTLE);
                check("done_pulse", done_pulse, cur.done);
                if (cur.done) check("done_zone", done_zone, cur.zone);
                busy_chk = 1'b1;
                c_vfall  = cyc;
            end else begin
                check("no_stray_done", done_pulse, 0);
            end
            if (busy_chk && cyc == c_vfall + GAP) begin
                check("gap_busy_off", busy, 0);
                busy_chk = 1'b0;
            end else if (busy_chk && cyc == c_vfall + GAP - 1) begin
                check("gap_busy_on", busy, 1);
            end
            prev_valve = valve_open;
            prev_pump  = pump_on;
        end
    end

    task automatic wait_busy(input logic val, input int lim, input string nm);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk); #1;
            if (busy == val) break;
        end
        check(nm, busy, val);
    endtask

    task automatic wait_pump(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk); #1;
            if (pump_on) break;
        end
        check("pump_wait", pump_on, 1);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk); #1;
        enable   = v.en;
        zone_req = v.req;
        zone_dur = v.dur;
        if (v.grant) begin
            sb_q.push_back('{zone: v.zone, dur: v.run, run: v.run, done: 1'b1});
            wait_busy(1'b1, 20, "grant_wait");
            zone_req = '0;
            wait_busy(1'b0, 600, "idle_wait");
        end else begin
            repeat (20) @(negedge clk);
            #1;
            check("no_grant", busy, 0);
            zone_req = '0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g0;
        vecs[0] = '{en: 1'b1, req: 4'b0100, dur: 32'h0005_0000, grant: 1'b1, zone: 3'd2, run: 5};
        vecs[1] = '{en: 1'b1, req: 4'b0011, dur: 32'h0000_0400, grant: 1'b1, zone: 3'd1, run: 4};
        vecs[2] = '{en: 1'b0, req: 4'b1111, dur: 32'h0303_0303, grant: 1'b0, zone: 3'd0, run: 0};
        vecs[3] = '{en: 1'b1, req: 4'b1111, dur: 32'h0303_0303, grant: 1'b1, zone: 3'd2, run: 3};
        vecs[4] = '{en: 1'b1, req: 4'b1011, dur: 32'h0707_0707, grant: 1'b1, zone: 3'd3, run: 7};
        vecs[5] = '{en: 1'b1, req: 4'b1001, dur: 32'h0900_0001, grant: 1'b1, zone: 3'd0, run: 1};
        vecs[6] = '{en: 1'b1, req: 4'b0001, dur: 32'h0000_0002, grant: 1'b1, zone: 3'd0, run: 2};
        vecs[7] = '{en: 1'b1, req: 4'b0000, dur: 32'h0101_0101, grant: 1'b0, zone: 3'd0, run: 0};
        vecs[8] = '{en: 1'b1, req: 4'b1000, dur: 32'h0001_0101, grant: 1'b0, zone: 3'd0, run: 0};
        vecs[9] = '{en: 1'b1, req: 4'b0010, dur: 32'h0000_FF00, grant: 1'b1, zone: 3'd1, run: 255};

        reset    = 1'b1;
        enable   = 1'b0;
        zone_req = '0;
        zone_dur = '0;
        rain     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pump", pump_on, 0);
        check("rst_valve", valve_open, 0);
        check("rst_busy", busy, 0);
        check("rst_zone", active_zone, 0);
        check("rst_rem", remaining, 0);
        check("rst_done", done_pulse, 0);
        check("rst_done_zone", done_zone, 0);
        #2 reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // All zones requesting continuously: strict round robin from zone 0.
        pulse_reset();
        for (int k = 0; k < 5; k++)
            sb_q.push_back('{zone: 3'(k % NZ), dur: 2, run: 2, done: 1'b1});
        g0 = grants;
        @(negedge clk); #1;
        enable   = 1'b1;
        zone_dur = 32'h0202_0202;
        zone_req = 4'b1111;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (grants >= g0 + 5) break;
        end
        zone_req = '0;
        wait_busy(1'b0, 100, "rr_idle");
        repeat (20) @(negedge clk);
        check("rr_count", grants - g0, 5);

        // Inputs changed mid-run must not affect the latched duration.
        sb_q.push_back('{zone: 3'd2, dur: 6, run: 6, done: 1'b1});
        @(negedge clk); #1;
        zone_dur = 32'h0006_0000;
        zone_req = 4'b0100;
        wait_pump(20);
        zone_req = '0;
        zone_dur = 32'h0101_0101;
        enable   = 1'b0;
        wait_busy(1'b0, 100, "latch_idle");
        enable = 1'b1;

        // Reset during RUN: outputs drop at once, no done, zone 0 first afterwards.
        sb_q.push_back('{zone: 3'd1, dur: 10, run: 10, done: 1'b1});
        @(negedge clk); #1;
        zone_dur = 32'h0000_0A00;
        zone_req = 4'b0010;
        wait_pump(20);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_pump", pump_on, 0);
        check("mid_rst_valve", valve_open, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done_pulse, 0);
        zone_req = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        sb_q.push_back('{zone: 3'd0, dur: 3, run: 3, done: 1'b1});
        zone_dur = 32'h0000_0303;
        zone_req = 4'b0011;
        wait_busy(1'b1, 20, "post_rst_grant");
        zone_req = '0;
        wait_busy(1'b0, 100, "post_rst_idle");

`ifdef RAIN_LOCKOUT_EN
        @(negedge clk); #1;
        rain     = 1'b1;
        zone_dur = 32'h0000_0004;
        zone_req = 4'b0001;
        repeat (20) @(negedge clk);
        #1;
        check("rain_block", busy, 0);
        sb_q.push_back('{zone: 3'd0, dur: 4, run: 2, done: 1'b0});
        rain = 1'b0;
        wait_busy(1'b1, 20, "rain_grant");
        zone_req = '0;
        wait_pump(20);
        @(negedge clk); #1;
        rain = 1'b1;
        @(negedge clk); #1;
        rain = 1'b0;
        wait_busy(1'b0, 100, "rain_idle");
`else
        sb_q.push_back('{zone: 3'd0, dur: 3, run: 3, done: 1'b1});
        @(negedge clk); #1;
        rain     = 1'b1;
        zone_dur = 32'h0000_0003;
        zone_req = 4'b0001;
        wait_busy(1'b1, 20, "rain_ign_grant");
        zone_req = '0;
        wait_busy(1'b0, 100, "rain_ign_idle");
        rain = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
